// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared codes, state encoding and default timing for the Morse transmit path
package morse_pkg;

    localparam logic [4:0] CODE_NONE  = 5'd0;
    localparam logic [4:0] CODE_A     = 5'd1;
    localparam logic [4:0] CODE_Z     = 5'd26;
    localparam logic [4:0] CODE_SPACE = 5'd31;

    localparam int FIFO_DEPTH_DEF  = 8;
    localparam int GAP_CHAR_MS_DEF = 300;
    localparam int GAP_WORD_MS_DEF = 700;
    localparam int BUSY_TO_DEF     = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_HI,
        WAIT_LO,
        GAP
    } sched_state_t;

endpackage

// File: rtl/morse_char_fifo.sv
// rtl/morse_char_fifo.sv - single-clock character queue with wrap-bit pointers
module morse_char_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Full/empty come from registered pointers, so a pop never frees a slot for a same-cycle push.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + CW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/morse_tx_scheduler.sv
// rtl/morse_tx_scheduler.sv - queues keypad/host characters and paces the buzzer driver
module morse_tx_scheduler
    import morse_pkg::*;
#(
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int GAP_CHAR_MS = GAP_CHAR_MS_DEF,
    parameter int GAP_WORD_MS = GAP_WORD_MS_DEF,
    parameter int BUSY_TO     = BUSY_TO_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_1khz,
    input  logic [4:0]                    key_code,
    input  logic                          key_valid,
    input  logic [4:0]                    host_code,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic                          clr_flags,
    input  logic                          buz_busy,
    output logic [4:0]                    char_code,
    output logic                          buz_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          active,
    output logic                          ovf,
    output logic                          err
);

    localparam int GAP_MAX = (GAP_CHAR_MS > GAP_WORD_MS) ? GAP_CHAR_MS : GAP_WORD_MS;
    localparam int GW      = $clog2(GAP_MAX + 1);
    localparam int TW      = $clog2(BUSY_TO + 1);

    localparam logic [GW-1:0] GAP_CHAR_CNT = GW'(GAP_CHAR_MS);
    localparam logic [GW-1:0] GAP_WORD_CNT = GW'(GAP_WORD_MS);
    localparam logic [TW-1:0] TO_LAST      = TW'(BUSY_TO - 1);

    sched_state_t  state_q, state_d;
    logic          key_valid_q;
    logic          kp_push;
    logic [4:0]    kp_code;
    logic [2:0]    khz_sync;
    logic          ms_tick;
    logic          host_push;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [4:0]    fifo_din, fifo_dout;
    logic [GW-1:0] gap_cnt, gap_val;
    logic          gap_load, gap_dec;
    logic [TW-1:0] to_cnt;
    logic          err_set;

    // Keypad wins collisions; the host just sees ready low and retries next cycle.
    assign host_ready = rst_n && !fifo_full && !kp_push;
    assign host_push  = host_valid && host_ready;
    assign fifo_push  = kp_push || host_push;
    assign fifo_din   = kp_push ? kp_code : host_code;
    assign ms_tick    = khz_sync[1] && !khz_sync[2];
    assign active     = (state_q != IDLE);

    morse_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (5)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_q <= 1'b0;
            kp_push     <= 1'b0;
            kp_code     <= '0;
            khz_sync    <= '0;
        end else begin
            key_valid_q <= key_valid;
            kp_push     <= key_valid && !key_valid_q;
            kp_code     <= key_code;
            khz_sync    <= {khz_sync[1:0], clk_1khz};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        buz_start = 1'b0;
        gap_load  = 1'b0;
        gap_val   = GAP_CHAR_CNT;
        gap_dec   = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (char_code == CODE_SPACE) begin
                    gap_load = 1'b1;
                    gap_val  = GAP_WORD_CNT;
                    state_d  = GAP;
                end else begin
                    state_d = START;
                end
            end
            START: begin
                buz_start = 1'b1;
                state_d   = WAIT_HI;
            end
            WAIT_HI: begin
                if (buz_busy) begin
                    state_d = WAIT_LO;
                end else if (to_cnt == TO_LAST) begin
                    err_set  = 1'b1;
                    gap_load = 1'b1;
                    state_d  = GAP;
                end
            end
            WAIT_LO: begin
                if (!buz_busy) begin
                    gap_load = 1'b1;
                    state_d  = GAP;
                end
            end
            GAP: begin
                // Gap is N ticks, so real silence is N-1..N ms depending on tick phase.
                if (ms_tick) begin
                    gap_dec = (gap_cnt != '0);
                    if (gap_cnt <= GW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_code <= '0;
            gap_cnt   <= '0;
            to_cnt    <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (fifo_pop) char_code <= fifo_dout;
            if (gap_load)     gap_cnt <= gap_val;
            else if (gap_dec) gap_cnt <= gap_cnt - GW'(1);
            if (state_q == WAIT_HI) to_cnt <= to_cnt + TW'(1);
            else                    to_cnt <= '0;
            ovf <= (kp_push && fifo_full) || (ovf && !clr_flags);
            err <= err_set || (err && !clr_flags);
        end
    end

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// tb/tb_morse_tx_scheduler.sv - randomized self-checking bench for morse_tx_scheduler
module tb_morse_tx_scheduler;
    import morse_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_1khz = 1'b0;
    logic [4:0] key_code = '0;
    logic       key_valid = 1'b0;
    logic [4:0] host_code = '0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic       clr_flags = 1'b0;
    logic       buz_busy;
    logic [4:0] char_code;
    logic       buz_start;
    logic [3:0] fifo_count;
    logic       active, ovf, err;

    int n_checks = 0;
    int n_fail = 0;
    int cycle = 0;
    int edges = 0;
    int busy_mode = 0;   // 0 normal pulse, 1 never busy, 2 stuck high
    int busy_len = 10;
    int busy_rem = 0;
    int pend = 0;
    int fall_edges = 0;
    logic [4:0] start_codes[$];
    int start_cycles[$];
    int start_edges[$];

    morse_tx_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_1khz   (clk_1khz),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .host_code  (host_code),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .clr_flags  (clr_flags),
        .buz_busy   (buz_busy),
        .char_code  (char_code),
        .buz_start  (buz_start),
        .fifo_count (fifo_count),
        .active     (active),
        .ovf        (ovf),
        .err        (err)
    );

    initial forever #5 clk = ~clk;
    // Fast stand-in for the 1 kHz divider: one "ms" every 8 clk cycles.
    initial begin #3; forever #40 clk_1khz = ~clk_1khz; end
    always @(posedge clk) cycle <= cycle + 1;
    always @(posedge clk_1khz) edges <= edges + 1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && buz_start === 1'b1) begin
                start_codes.push_back(char_code);
                start_cycles.push_back(cycle);
                start_edges.push_back(edges);
            end
        end
    end

    // Buzzer driver model
    initial begin
        buz_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1 || busy_mode == 1) begin
                buz_busy = 1'b0;
                pend = 0;
            end else if (busy_mode == 2) begin
                buz_busy = 1'b1;
                busy_rem = 0;
            end else if (buz_busy) begin
                if (busy_rem <= 1) begin
                    buz_busy = 1'b0;
                    fall_edges = edges;
                end else busy_rem--;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    buz_busy = 1'b1;
                    busy_rem = busy_len;
                end
            end else if (buz_start === 1'b1) pend = 2;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        rst_n = 1'b0; key_valid = 1'b0; host_valid = 1'b0; clr_flags = 1'b0; busy_mode = 0;
        repeat (3) @(negedge clk);
        start_codes.delete(); start_cycles.delete(); start_edges.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_starts(input int n, input int budget, input string name);
        int k = 0;
        while (start_codes.size() < n && k < budget) begin @(negedge clk); k++; end
        n_checks++;
        if (start_codes.size() < n) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d starts, required %0d", name, start_codes.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while ((active !== 1'b0 || fifo_count !== 4'd0) && k < budget) begin @(negedge clk); k++; end
        n_checks++;
        if (active !== 1'b0 || fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL %s_idle: active=%0b count=%0d, required 0 0", name, active, fifo_count);
        end
    endtask

    task automatic host_push(input logic [4:0] c);
        host_valid = 1'b1; host_code = c;
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL reset_host_ready: got %b required 0", host_ready); end
        n_checks++; if (char_code !== 5'd0) begin n_fail++; $display("FAIL reset_char_code: got %0d required 0", char_code); end
        n_checks++; if (buz_start !== 1'b0) begin n_fail++; $display("FAIL reset_buz_start: got %b required 0", buz_start); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d required 0", fifo_count); end
        n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b required 0", active); end
        n_checks++; if ({ovf, err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b%b required 00", ovf, err); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b required 1", host_ready); end
    endtask

    task automatic test_single_key;
        logic [4:0] c1, c2;
        int c0, gap;
        do_reset();
        busy_len = 1000;
        c1 = 5'($urandom_range(1, 30));
        c2 = 5'($urandom_range(1, 30));
        key_valid = 1'b1; key_code = c1; c0 = cycle;
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d required 1", fifo_count); end
        key_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (active !== 1'b1 || buz_start !== 1'b0) begin n_fail++; $display("FAIL single_load: active=%b start=%b required 1 0", active, buz_start); end
        @(negedge clk); #1;
        n_checks++; if (buz_start !== 1'b1 || char_code !== c1 || cycle !== c0 + 4) begin
            n_fail++; $display("FAIL single_start: start=%b code=%0d cycle=%0d required 1 %0d %0d", buz_start, char_code, cycle, c1, c0 + 4); end
        @(negedge clk); #1;
        n_checks++; if (buz_start !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b required 0", buz_start); end
        repeat (5) @(negedge clk);
        host_push(c2);
        wait_starts(2, 8000, "single");
        if (start_codes.size() >= 2) begin
            gap = start_edges[1] - fall_edges;
            n_checks++; if (start_codes[1] !== c2) begin n_fail++; $display("FAIL single_second_code: got %0d required %0d", start_codes[1], c2); end
            n_checks++; if (gap < GAP_CHAR_MS_DEF - 1 || gap > GAP_CHAR_MS_DEF + 1) begin
                n_fail++; $display("FAIL single_char_gap: got %0d ms required %0d +-1", gap, GAP_CHAR_MS_DEF); end
        end
        wait_idle(6000, "single");
    endtask

    task automatic test_overflow;
        logic [4:0] first, c;
        logic [4:0] exp_q[$];
        int dropped = 0;
        do_reset();
        busy_mode = 2;
        first = 5'($urandom_range(1, 30));
        host_push(first);
        wait_starts(1, 50, "ovf_first");
        for (int i = 0; i < FIFO_DEPTH_DEF + 1; i++) begin
            c = 5'($urandom_range(1, 30));
            if (exp_q.size() < FIFO_DEPTH_DEF) exp_q.push_back(c);
            else dropped++;
            key_valid = 1'b1; key_code = c;
            @(negedge clk);
            key_valid = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (2) @(negedge clk); #1;
        n_checks++; if (fifo_count !== 4'(exp_q.size())) begin n_fail++; $display("FAIL ovf_count: got %0d required %0d", fifo_count, exp_q.size()); end
        n_checks++; if (ovf !== (dropped > 0)) begin n_fail++; $display("FAIL ovf_flag: got %b required %b", ovf, dropped > 0); end
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b required 0", ovf); end
        busy_len = $urandom_range(5, 40);
        busy_mode = 0;
        wait_starts(exp_q.size() + 1, 30000, "ovf_drain");
        n_checks++; if (start_codes.size() < 1 || start_codes[0] !== first) begin n_fail++; $display("FAIL ovf_first_code: required %0d", first); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (start_codes.size() <= i + 1 || start_codes[i + 1] !== exp_q[i]) begin
                n_fail++; $display("FAIL ovf_order[%0d]: required %0d", i, exp_q[i]); end
        end
        wait_idle(4000, "ovf");
    endtask

    task automatic test_collision;
        logic [4:0] a, b;
        do_reset();
        busy_len = 20;
        a = 5'($urandom_range(1, 30));
        b = 5'($urandom_range(1, 30));
        key_valid = 1'b1; key_code = a;
        @(negedge clk);
        host_valid = 1'b1; host_code = b; #1;
        n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL coll_ready_low: got %b required 0", host_ready); end
        @(negedge clk); #1;
        n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL coll_ready_high: got %b required 1", host_ready); end
        @(negedge clk); #1;
        host_valid = 1'b0; key_valid = 1'b0;
        n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL coll_count: got %0d required 1", fifo_count); end
        wait_starts(2, 6000, "coll");
        wait_idle(4000, "coll");
        n_checks++; if (start_codes.size() != 2 || start_codes[0] !== a || start_codes[1] !== b) begin
            n_fail++; $display("FAIL coll_order: got %0d starts, required codes %0d then %0d", start_codes.size(), a, b); end
    endtask

    task automatic test_space;
        int h, gap;
        do_reset();
        busy_len = $urandom_range(10, 50);
        h = cycle;
        host_valid = 1'b1; host_code = 5'd3;
        @(negedge clk); host_code = CODE_SPACE;
        @(negedge clk); host_code = 5'd4;
        @(negedge clk); host_valid = 1'b0;
        wait_starts(2, 15000, "space");
        if (start_codes.size() >= 2) begin
            gap = start_edges[1] - fall_edges;
            n_checks++; if (start_cycles[0] !== h + 3) begin n_fail++; $display("FAIL host_latency: got %0d required %0d", start_cycles[0], h + 3); end
            n_checks++; if (start_codes[0] !== 5'd3 || start_codes[1] !== 5'd4) begin
                n_fail++; $display("FAIL space_codes: got %0d %0d required 3 4", start_codes[0], start_codes[1]); end
            n_checks++; if (gap < GAP_CHAR_MS_DEF + GAP_WORD_MS_DEF - 2 || gap > GAP_CHAR_MS_DEF + GAP_WORD_MS_DEF + 2) begin
                n_fail++; $display("FAIL space_gap: got %0d ms required %0d +-2", gap, GAP_CHAR_MS_DEF + GAP_WORD_MS_DEF); end
        end
        wait_idle(4000, "space");
        n_checks++; if (start_codes.size() != 2) begin n_fail++; $display("FAIL space_start_count: got %0d required 2", start_codes.size()); end
    endtask

    task automatic test_busy_timeout;
        logic [4:0] p, q;
        int s;
        do_reset();
        busy_mode = 1;
        p = 5'($urandom_range(1, 30));
        q = 5'($urandom_range(1, 30));
        host_push(p);
        host_push(q);
        wait_starts(1, 50, "to_first");
        s = (start_cycles.size() > 0) ? start_cycles[0] : cycle;
        while (cycle < s + BUSY_TO_DEF) @(negedge clk);
        #1;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b required 0", err); end
        @(negedge clk); #1;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b required 1", err); end
        wait_starts(2, 6000, "to_drain");
        wait_idle(6000, "to");
        n_checks++; if (start_codes.size() != 2 || start_codes[0] !== p || start_codes[1] !== q) begin
            n_fail++; $display("FAIL to_codes: got %0d starts, required %0d then %0d", start_codes.size(), p, q); end
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        #1;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b required 0", err); end
    endtask

    task automatic test_reset_mid_gap;
        int n;
        do_reset();
        busy_len = 8;
        for (int i = 0; i < 4; i++) host_push(5'($urandom_range(1, 30)));
        wait_starts(1, 50, "mid");
        repeat (40) @(negedge clk);
        #1;
        n_checks++; if (fifo_count !== 4'd3 || active !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: count=%0d active=%b required 3 1", fifo_count, active); end
        @(negedge clk);
        rst_n = 1'b0; #1;
        n_checks++; if (buz_start !== 1'b0 || fifo_count !== 4'd0 || active !== 1'b0 || host_ready !== 1'b0 || char_code !== 5'd0) begin
            n_fail++; $display("FAIL mid_reset: start=%b count=%0d active=%b ready=%b code=%0d required 0 0 0 0 0",
                               buz_start, fifo_count, active, host_ready, char_code); end
        n = start_codes.size();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3000) @(negedge clk);
        #1;
        n_checks++; if (start_codes.size() != n || active !== 1'b0) begin
            n_fail++; $display("FAIL mid_after: starts=%0d active=%b required %0d 0", start_codes.size(), active, n); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_overflow();
        test_collision();
        test_space();
        test_busy_timeout();
        test_reset_mid_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
